// File: rtl/mux81_scan_seq.sv
// mux81_scan_seq: round-robin scan sequencer for the 8:1 8-bit mux.
// Walks the registered select through every enabled channel in ascending
// order, captures each mux output and hands it downstream over valid/ready.
// A modulo-256 checksum of the scan is reported with a one-cycle done pulse.
module mux81_scan_seq #(
   parameter int WIDTH = 8,
   parameter int NCH   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NCH-1:0]   mask,
   output logic [2:0]       sel,
   input  logic [WIDTH-1:0] mux_out,
   output logic [WIDTH-1:0] data_out,
   output logic [2:0]       ch_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] checksum
);

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      HOLD,
      FINISH
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [NCH-1:0]   mask_q;
   logic [WIDTH-1:0] acc;

   // Next-value signals for every registered output and internal register.
   logic [2:0]       sel_d;
   logic [NCH-1:0]   mask_d;
   logic [WIDTH-1:0] acc_d;
   logic [WIDTH-1:0] data_d;
   logic [2:0]       ch_d;
   logic             valid_d;
   logic             busy_d;
   logic             done_d;
   logic [WIDTH-1:0] checksum_d;

   // Channel search results.
   logic [2:0]       low_ch;
   logic             low_found;
   logic [2:0]       next_ch;
   logic             next_found;
   logic [2:0]       bit_idx;

   logic             accept;
   logic             handshake;

   // IDLE refuses start during the done cycle: busy is still high there,
   // so a new scan can only begin once busy has dropped.
   assign accept    = (state == IDLE) && start && !done;
   assign handshake = out_valid && out_ready;

   // Find the lowest set bit of the incoming mask and the lowest latched
   // channel above the current select; descending loops leave the lowest hit.
   always_comb begin
      low_ch     = '0;
      low_found  = 1'b0;
      next_ch    = '0;
      next_found = 1'b0;
      bit_idx    = '0;
      for (int unsigned i = NCH; i > 0; i--) begin
         bit_idx = 3'(i - 1);
         if (mask[bit_idx]) begin
            low_ch    = bit_idx;
            low_found = 1'b1;
         end
      end
      for (int unsigned i = NCH; i > 0; i--) begin
         bit_idx = 3'(i - 1);
         if (mask_q[bit_idx] && (bit_idx > sel)) begin
            next_ch    = bit_idx;
            next_found = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = low_found ? SETTLE : FINISH;
            end
         end
         SETTLE: begin
            state_nxt = HOLD;
         end
         HOLD: begin
            if (handshake) begin
               state_nxt = next_found ? SETTLE : FINISH;
            end
         end
         FINISH: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output/datapath next values; all outputs are registered below so no
   // input reaches an output combinationally.
   always_comb begin
      sel_d      = sel;
      mask_d     = mask_q;
      acc_d      = acc;
      data_d     = data_out;
      ch_d       = ch_out;
      valid_d    = out_valid;
      checksum_d = checksum;
      done_d     = 1'b0;
      busy_d     = busy;

      if (accept) begin
         busy_d = 1'b1;
      end else if (done) begin
         busy_d = 1'b0;
      end

      case (state)
         IDLE: begin
            if (accept) begin
               mask_d = mask;
               acc_d  = '0;
               if (low_found) begin
                  sel_d = low_ch;
               end
            end
         end
         SETTLE: begin
            data_d  = mux_out;
            ch_d    = sel;
            acc_d   = acc + mux_out;
            valid_d = 1'b1;
         end
         HOLD: begin
            if (handshake) begin
               valid_d = 1'b0;
               if (next_found) begin
                  sel_d = next_ch;
               end
            end
         end
         FINISH: begin
            checksum_d = acc;
            done_d     = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel       <= '0;
         mask_q    <= '0;
         acc       <= '0;
         data_out  <= '0;
         ch_out    <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
      end else begin
         sel       <= sel_d;
         mask_q    <= mask_d;
         acc       <= acc_d;
         data_out  <= data_d;
         ch_out    <= ch_d;
         out_valid <= valid_d;
         busy      <= busy_d;
         done      <= done_d;
         checksum  <= checksum_d;
      end
   end

endmodule
